sprite_fetch_master: RTL and testbench

- Avalon-MM read master for the 16-bit x 1024 on-chip sprite/pattern RAMs (p1-style single-port memories with byteenable and a 1-cycle synchronous read).
- On a start command it reads a contiguous run of words, buffers them in a small FIFO and presents them as a valid/ready stream to the pixel/display pipeline.
- Sits between the sprite RAM slave port and the video renderer.

---
 rtl/sprite_fetch_pkg.sv | 21 ++
 rtl/sprite_fetch_fifo.sv | 72 +++++++
 rtl/sprite_fetch_master.sv | 171 +++++++++++++++++
 tb/tb_sprite_fetch_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_fetch_pkg.sv
// ---------------------------------------------------------------------------
// sprite_fetch_pkg
// Shared constants and types for the sprite RAM read master.
//   ADDR_W     : word-address width of the sprite/pattern RAM (1024 words)
//   DATA_W     : RAM data word width
//   RD_LATENCY : fixed read latency of the on-chip RAM slave, in cycles
//   state_e    : read-master FSM states
// ---------------------------------------------------------------------------
package sprite_fetch_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 16;
  localparam int RD_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sprite_fetch_fifo.sv
// ---------------------------------------------------------------------------
// sprite_fetch_fifo
// Small synchronous FIFO (power-of-two depth, minimum 2). The head word is
// presented combinationally on pop_data_o, so a word pushed into an empty
// FIFO is visible the cycle after the push.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (pointers/count only)
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : word to write
//   pop_i         : drop the head word (ignored when empty)
//   pop_data_o    : head word
//   empty_o       : no words stored
//   full_o        : FIFO_DEPTH words stored
//   count_o       : number of words stored, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module sprite_fetch_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             pop_data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == DEPTH_C);
  assign count_o    = cnt_q;
  assign pop_data_o = mem_q[rd_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/sprite_fetch_master.sv
// ---------------------------------------------------------------------------
// sprite_fetch_master
// Avalon-MM read master that fetches a contiguous run of words from a
// single-port on-chip sprite RAM (1-cycle read latency) and streams them to
// the renderer through a small FIFO with a valid/ready handshake.
// Build option: define SPRITE_FETCH_CHECKSUM_EN to build a running sum of the
// streamed words on `checksum`; otherwise `checksum` is tied to zero.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : command strobe, honoured only when idle
//   start_addr        : first word address of the run
//   length            : number of words, 0..1024
//   busy              : run in progress
//   done              : one-cycle pulse once the run is fully delivered
//   avm_*             : Avalon-MM read master port
//   out_data/valid    : stream output (FIFO head / FIFO non-empty)
//   out_ready         : downstream accept
//   checksum          : sum of words streamed since the last start
// ---------------------------------------------------------------------------
module sprite_fetch_master #(
  parameter int ADDR_W     = sprite_fetch_pkg::ADDR_W,
  parameter int DATA_W     = sprite_fetch_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W:0]       length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     checksum
);

  import sprite_fetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              inflight_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full;
  logic [CNT_W:0]    used;
  logic              credit, rd_accept, pop;

  // A read is only issued when the FIFO is guaranteed room for its data,
  // counting the word still on its way back from the RAM.
  assign used      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign credit    = (used < (CNT_W+1)'(FIFO_DEPTH));
  assign avm_read  = (state_q == FETCH) & credit;
  assign rd_accept = avm_read & ~avm_waitrequest;

  assign avm_chipselect = avm_read;
  assign avm_address    = addr_q;
  assign avm_byteenable = '1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign out_valid      = ~fifo_empty;
  assign pop            = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            addr_d  = start_addr;
            rem_d   = length;
            busy_d  = 1'b1;
            state_d = FETCH;
          end else begin
            // Empty run: acknowledge immediately without touching the bus.
            done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (rd_accept) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inflight_q <= rd_accept;
    end
  end

  // Read data returns exactly one cycle after acceptance; clearing
  // inflight_q on reset discards any word still in flight.
  sprite_fetch_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (avm_readdata),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  // The credit rule makes a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset && inflight_q) assert (!fifo_full);
  end

`ifdef SPRITE_FETCH_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cksum_q <= '0;
    end else if (state_q == IDLE && start) begin
      cksum_q <= '0;
    end else if (pop) begin
      cksum_q <= cksum_q + out_data;
    end
  end

  assign checksum = cksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sprite_fetch_master.sv
// ---------------------------------------------------------------------------
// tb_sprite_fetch_master
// Directed scenarios with a scoreboard: each run pushes the expected read
// addresses and stream words into queues; a monitor thread pops and compares
// whenever the DUT accepts a read or hands over a stream word.
// ---------------------------------------------------------------------------
module tb_sprite_fetch_master;

  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic [AW:0]     length;
  logic            busy, done;
  logic [AW-1:0]   avm_address;
  logic            avm_chipselect, avm_read;
  logic [DW/8-1:0] avm_byteenable;
  logic            avm_waitrequest;
  logic [DW-1:0]   avm_readdata;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_ready;
  logic [DW-1:0]   checksum;

  always #5 clk = ~clk;

  sprite_fetch_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .start_addr      (start_addr),
    .length          (length),
    .busy            (busy),
    .done            (done),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_read        (avm_read),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .checksum        (checksum)
  );

  // RAM slave model: 1-cycle synchronous read, word[i] = i.
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) rdata <= ram[avm_address];
  end
  assign avm_readdata = rdata;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int run_done0 = 0;
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] run_ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] a, input int len);
    logic [AW-1:0] p;
    p = a;
    run_ck = '0;
    run_done0 = done_cnt;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(p);
      exp_data.push_back(ram[p]);
      run_ck = run_ck + ram[p];
      p = p + 1'b1;
    end
    start_addr = a;
    length     = (AW+1)'(len);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == run_done0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != run_done0), 32'd1);
    repeat (3) tick();
  endtask

  task automatic finish_run(input string name);
    chk({name, "_done_once"}, 32'(done_cnt - run_done0), 32'd1);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_words_left"}, 32'(exp_data.size()), 32'd0);
    chk({name, "_reads_left"}, 32'(exp_addr.size()), 32'd0);
`ifdef SPRITE_FETCH_CHECKSUM_EN
    chk({name, "_checksum"}, 32'(checksum), 32'(run_ck));
`else
    chk({name, "_checksum"}, 32'(checksum), 32'd0);
`endif
    exp_data.delete();
    exp_addr.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] pat;
    int a0, p0, n;

    for (int i = 0; i < 1024; i++) ram[i] = DW'(i);
    reset = 1'b1; start = 1'b0; start_addr = '0; length = '0;
    avm_waitrequest = 1'b0; out_ready = 1'b1;

    // Monitor: scoreboard comparisons on every read acceptance / stream word.
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (out_valid && out_ready) begin
            pop_cnt++;
            if (exp_data.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL stream_word: got 0x%0h with no word expected", out_data);
            end else begin
              chk("stream_word", 32'(out_data), 32'(exp_data.pop_front()));
            end
          end
          if (avm_read && !avm_waitrequest) begin
            acc_cnt++;
            chk("read_chipselect", 32'(avm_chipselect), 32'd1);
            if (exp_addr.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL read_addr: got 0x%0h with no read expected", avm_address);
            end else begin
              chk("read_addr", 32'(avm_address), 32'(exp_addr.pop_front()));
            end
          end
          if (done) done_cnt++;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_cs", 32'(avm_chipselect), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("byteenable", 32'(avm_byteenable), 32'h3);
    reset = 1'b0;
    tick();

    // Basic run: 0x010..0x017
    launch(10'h010, 8);
    chk("basic_busy_high", 32'(busy), 32'd1);
    wait_done("basic", 100);
    finish_run("basic");
`ifdef SPRITE_FETCH_CHECKSUM_EN
    chk("basic_checksum_hand", 32'(checksum), 32'h009C);
`endif

    // Address wrap 0x3FE -> 0x001
    launch(10'h3FE, 4);
    wait_done("wrap", 100);
    finish_run("wrap");

    // Waitrequest on the 2nd read, with an ignored start during the run
    a0 = acc_cnt;
    launch(10'h020, 6);
    n = 0;
    while (acc_cnt == a0 && n < 20) begin
      tick();
      n++;
    end
    chk("wr_first_read", 32'(acc_cnt - a0), 32'd1);
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wr_read_held", 32'(avm_read), 32'd1);
      chk("wr_addr_held", 32'(avm_address), 32'h021);
      @(posedge clk);
      #1;
      if (k == 0) begin
        start = 1'b1; start_addr = 10'h300; length = 11'd3;
      end else begin
        start = 1'b0;
      end
    end
    avm_waitrequest = 1'b0;
    start = 1'b0;
    wait_done("waitreq", 100);
    finish_run("waitreq");

    // Backpressure: toggling ready, then ready low for 10 cycles
    pat = 8'b1011_0010;
    a0 = acc_cnt;
    p0 = pop_cnt;
    launch(10'h040, 16);
    for (int i = 0; i < 8; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("bp_read_low", 32'(avm_read), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_outstanding", 32'((acc_cnt - a0) - (pop_cnt - p0)), 32'(DEPTH));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("bp", 200);
    finish_run("bp");

    // Zero length
    a0 = acc_cnt;
    launch(10'h123, 0);
    chk("zero_done_now", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    wait_done("zero", 10);
    finish_run("zero");
    chk("zero_no_read", 32'(acc_cnt - a0), 32'd0);

    // Full length from 0x200 (wraps through 0x3FF)
    launch(10'h200, 1024);
    wait_done("full", 2000);
    finish_run("full");

    // Reset in the middle of a 32-word run
    launch(10'h100, 32);
    repeat (4) tick();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_data.delete();
    exp_addr.delete();
    chk("rm_read", 32'(avm_read), 32'd0);
    chk("rm_valid", 32'(out_valid), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_checksum", 32'(checksum), 32'd0);
    tick();
    launch(10'h050, 2);
    wait_done("after_rst", 100);
    finish_run("after_rst");
`ifdef SPRITE_FETCH_CHECKSUM_EN
    chk("after_rst_checksum_hand", 32'(checksum), 32'h00A1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
